ad7656_sample_scheduler: RTL and testbench

- Sequences the three-device AD7656 acquisition array:
  - generates the periodic one-cycle start pulse for all read drivers;
  - gathers the per-ADC conversion-done strobes, with a timeout;
  - snapshots the 18 sensor words;
  - serialises them as a framed 16-bit valid/ready stream toward the packet/FIFO stage.
- Sits between system control registers and the ADC wrapper's start/done/data interface.

---
 rtl/ad7656_pkg.sv | 19 +
 rtl/ad7656_sample_scheduler_if.sv | 24 ++
 rtl/ad7656_period_tick.sv | 31 +++
 rtl/ad7656_sample_scheduler.sv | 129 ++++++++++++
 tb/tb_ad7656_sample_scheduler.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad7656_pkg.sv
// Shared definitions for the AD7656 acquisition sequencer: FSM encoding,
// default array geometry and status-counter width.
package ad7656_pkg;

    localparam int DATA_W          = 16;
    localparam int ADC_NUM_DEF     = 3;
    localparam int SENSOR_NUM_DEF  = 18;
    localparam int TIMEOUT_CYC_DEF = 5000;
    localparam int CNT_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_SNAPSHOT  = 3'd3,
        ST_STREAM    = 3'd4
    } state_t;

endpackage

// File: rtl/ad7656_sample_scheduler_if.sv
// Framed sensor-word stream from the sequencer toward the packet/FIFO stage.
interface ad7656_sample_scheduler_if #(
    parameter int CH_W = 5
);
    import ad7656_pkg::*;

    logic              m_valid_o;
    logic              m_ready_i;
    logic [DATA_W-1:0] m_data_o;
    logic [CH_W-1:0]   m_ch_o;
    logic              m_sof_o;
    logic              m_eof_o;

    modport master (
        output m_valid_o, m_data_o, m_ch_o, m_sof_o, m_eof_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o, m_data_o, m_ch_o, m_sof_o, m_eof_o,
        output m_ready_i
    );

endinterface

// File: rtl/ad7656_period_tick.sv
// Free-running sample-period counter; the period is clamped to >= 2 and only
// re-read at each wrap (or continuously while disabled).
module ad7656_period_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] cnt;
    logic [31:0] per;
    logic [31:0] per_eff;

    assign per_eff = (per < 32'd2) ? 32'd2 : per;
    assign tick    = enable && (cnt == per_eff - 32'd1);

    // Loading while disabled means the first period after enable uses the current input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            per <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
            per <= period;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ad7656_sample_scheduler.sv
// AD7656 array sequencer: periodic start pulse, done gathering with timeout,
// sensor snapshot and a framed valid/ready word stream.
module ad7656_sample_scheduler
    import ad7656_pkg::*;
#(
    parameter int ADC_NUM     = ADC_NUM_DEF,
    parameter int SENSOR_NUM  = SENSOR_NUM_DEF,
    parameter int CH_W        = 5,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                         sys_clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [31:0]                  period_i,
    output logic                         start_flag_o,
    input  logic [ADC_NUM-1:0]           convst_done_i,
    input  logic [SENSOR_NUM*DATA_W-1:0] wr_dout_i,
    ad7656_sample_scheduler_if.master    m_if,
    output logic [CNT_W-1:0]             frame_cnt_o,
    output logic                         overrun_o,
    output logic                         timeout_o,
    output logic [CNT_W-1:0]             overrun_cnt_o,
    output logic [CNT_W-1:0]             timeout_cnt_o,
    output logic                         busy_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             state, state_nxt;
    logic               tick;
    logic [ADC_NUM-1:0] done_seen;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [CH_W-1:0]    ch;
    logic [DATA_W-1:0]  shadow [SENSOR_NUM];
    logic               all_done;
    logic               tmo_hit;
    logic               last_ch;

    ad7656_period_tick u_tick (
        .clk    (sys_clk_i),
        .rst    (rst_i),
        .enable (enable_i),
        .period (period_i),
        .tick   (tick)
    );

    // A strobe arriving in the final wait cycle still counts, so done beats timeout.
    assign all_done = &(done_seen | convst_done_i);
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign last_ch  = (ch == CH_W'(SENSOR_NUM - 1));

    assign start_flag_o = (state == ST_START);
    assign busy_o       = (state != ST_IDLE);
    assign overrun_o    = tick && (state != ST_IDLE);
    assign timeout_o    = (state == ST_WAIT_DONE) && !all_done && tmo_hit;

    assign m_if.m_valid_o = (state == ST_STREAM);
    assign m_if.m_data_o  = shadow[ch];
    assign m_if.m_ch_o    = ch;
    assign m_if.m_sof_o   = (state == ST_STREAM) && (ch == '0);
    assign m_if.m_eof_o   = (state == ST_STREAM) && last_ch;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (tick) state_nxt = ST_START;
            ST_START:     state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (all_done)     state_nxt = ST_SNAPSHOT;
                else if (tmo_hit) state_nxt = ST_IDLE;
            end
            ST_SNAPSHOT:  state_nxt = ST_STREAM;
            ST_STREAM:    if (m_if.m_ready_i && last_ch) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            done_seen     <= '0;
            tmo_cnt       <= '0;
            ch            <= '0;
            frame_cnt_o   <= '0;
            overrun_cnt_o <= '0;
            timeout_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (overrun_o) overrun_cnt_o <= sat_inc(overrun_cnt_o);
            if (timeout_o) timeout_cnt_o <= sat_inc(timeout_cnt_o);
            case (state)
                ST_START: begin
                    done_seen <= '0;
                    tmo_cnt   <= '0;
                end
                ST_WAIT_DONE: begin
                    done_seen <= done_seen | convst_done_i;
                    tmo_cnt   <= tmo_cnt + 1'b1;
                end
                ST_SNAPSHOT: ch <= '0;
                ST_STREAM: begin
                    if (m_if.m_ready_i) begin
                        if (last_ch) begin
                            ch          <= '0;
                            frame_cnt_o <= frame_cnt_o + 1'b1;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow copy keeps the stream stable while the ADC wrapper moves on.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < SENSOR_NUM; k++) shadow[k] <= '0;
        end else if (state == ST_SNAPSHOT) begin
            for (int k = 0; k < SENSOR_NUM; k++) shadow[k] <= wr_dout_i[k*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_ad7656_sample_scheduler.sv
// Randomised bench for ad7656_sample_scheduler with a cycle-timed event model.
module tb_ad7656_sample_scheduler;

    localparam int ADC_N = 3;
    localparam int SN    = 18;
    localparam int CHW   = 5;
    localparam int TMO   = 5000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [31:0]       period = '0;
    logic              start_flag;
    logic [ADC_N-1:0]  done = '0;
    logic [SN*16-1:0]  wr_dout = '0;
    logic [15:0]       frame_cnt, overrun_cnt, timeout_cnt;
    logic              overrun, timeout, busy;

    ad7656_sample_scheduler_if #(.CH_W(CHW)) s_if ();

    ad7656_sample_scheduler #(
        .ADC_NUM(ADC_N), .SENSOR_NUM(SN), .CH_W(CHW), .TIMEOUT_CYC(TMO)
    ) dut (
        .sys_clk_i     (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .period_i      (period),
        .start_flag_o  (start_flag),
        .convst_done_i (done),
        .wr_dout_i     (wr_dout),
        .m_if          (s_if),
        .frame_cnt_o   (frame_cnt),
        .overrun_o     (overrun),
        .timeout_o     (timeout),
        .overrun_cnt_o (overrun_cnt),
        .timeout_cnt_o (timeout_cnt),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int adc_dly [ADC_N] = '{50, 60, 70};
    int start_cyc = -100000;
    int ready_pct = 100;
    bit stray     = 1'b0;

    int starts[$];
    int vrise[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s cycle %0d: got no event expected event within bound", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < SN; k++) wr_dout[k*16 +: 16] = 16'($urandom);
        for (int i = 0; i < ADC_N; i++)
            done[i] = (adc_dly[i] >= 0) && (cyc == start_cyc + adc_dly[i]);
        if (stray && $urandom_range(0, 19) == 0) done[$urandom_range(0, ADC_N-1)] = 1'b1;
        s_if.m_ready_i = ($urandom_range(0, 99) < ready_pct);
        #1;
    endtask

    task automatic wait_frames(input int target, input int bound);
        int n = 0;
        while (frame_cnt != 16'(target) && n < bound) begin step(); n++; end
        if (frame_cnt != 16'(target)) expire("wait_frames");
    endtask

    // ---------------- reference model: absolute-cycle event bookkeeping ----------------
    int               m_next_tick = 0;
    int               m_start_at  = -1;
    int               m_snap_at   = -1;
    logic [ADC_N-1:0] m_seen      = '0;
    logic [15:0]      m_q[$];
    int               m_k = 0;
    int               m_frames = 0, m_ovr = 0, m_tmo = 0;
    bit               e_tick, e_busy, e_wait, e_snap, e_stream, e_timeout, e_ovr;
    bit               pv_valid = 0, pv_ready = 0;
    logic [15:0]      pv_data = '0;
    logic [CHW-1:0]   pv_ch = '0;

    always @(negedge clk) begin
        if (rst) begin
            m_q.delete();
            m_start_at = -1; m_snap_at = -1; m_seen = '0; m_k = 0;
            m_frames = 0; m_ovr = 0; m_tmo = 0;
            m_next_tick = cyc + 2;
            pv_valid = 0;
            chk("rst_valid", s_if.m_valid_o, 0);
            chk("rst_data", s_if.m_data_o, 0);
            chk("rst_ch", s_if.m_ch_o, 0);
            chk("rst_sof_eof", {s_if.m_sof_o, s_if.m_eof_o}, 0);
            chk("rst_pulses", {start_flag, overrun, timeout, busy}, 0);
            chk("rst_counts", {frame_cnt, overrun_cnt, timeout_cnt}, 0);
        end else begin
            e_tick   = enable && (cyc == m_next_tick);
            e_busy   = (m_start_at >= 0);
            e_wait   = e_busy && (cyc > m_start_at) && (m_snap_at < 0);
            e_snap   = (cyc == m_snap_at);
            e_stream = (m_q.size() > 0);
            e_timeout = 1'b0;
            if (e_wait) begin
                m_seen = m_seen | done;
                if (&m_seen) m_snap_at = cyc + 1;
                else if (cyc == m_start_at + TMO) e_timeout = 1'b1;
            end
            e_ovr = e_tick && e_busy;

            chk("start_flag", start_flag, e_busy && (cyc == m_start_at));
            chk("busy", busy, e_busy);
            chk("timeout", timeout, e_timeout);
            chk("overrun", overrun, e_ovr);
            chk("valid", s_if.m_valid_o, e_stream);
            chk("frame_cnt", frame_cnt, m_frames);
            chk("overrun_cnt", overrun_cnt, m_ovr);
            chk("timeout_cnt", timeout_cnt, m_tmo);
            if (e_stream) begin
                chk("data", s_if.m_data_o, m_q[0]);
                chk("ch", s_if.m_ch_o, m_k);
                chk("sof", s_if.m_sof_o, m_k == 0);
                chk("eof", s_if.m_eof_o, m_k == SN-1);
            end
            if (pv_valid && !pv_ready) begin
                chk("stall_data", s_if.m_data_o, pv_data);
                chk("stall_ch", s_if.m_ch_o, pv_ch);
            end

            if (start_flag) begin starts.push_back(cyc); start_cyc = cyc; end
            if (s_if.m_valid_o && !pv_valid) vrise.push_back(cyc);
            pv_valid = s_if.m_valid_o; pv_ready = s_if.m_ready_i;
            pv_data  = s_if.m_data_o;  pv_ch    = s_if.m_ch_o;

            if (e_timeout) begin
                m_tmo = (m_tmo == 65535) ? m_tmo : m_tmo + 1;
                m_start_at = -1;
            end
            if (e_ovr) m_ovr = (m_ovr == 65535) ? m_ovr : m_ovr + 1;
            if (e_snap) begin
                for (int k = 0; k < SN; k++) m_q.push_back(wr_dout[k*16 +: 16]);
                m_k = 0;
            end
            if (e_stream && s_if.m_ready_i) begin
                void'(m_q.pop_front());
                m_k++;
                if (m_q.size() == 0) begin
                    m_frames = (m_frames + 1) & 16'hFFFF;
                    m_start_at = -1;
                    m_snap_at = -1;
                end
            end
            if (e_tick && !e_busy) begin
                m_start_at = cyc + 1;
                m_seen = '0;
                m_snap_at = -1;
            end
            if (!enable || e_tick) m_next_tick = cyc + ((period < 2) ? 2 : int'(period));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int e_cyc;
        int n;
        s_if.m_ready_i = 1'b0;
        repeat (3) step();
        period = 32'd1000;
        rst = 1'b0;
        step();
        enable = 1'b1;
        e_cyc = cyc;

        // Basic frames
        wait_frames(3, 3500);
        enable = 1'b0;
        chk("basic_nstarts", starts.size(), 3);
        chk("basic_first_start", starts[0] - e_cyc, 1000);
        chk("basic_period1", starts[1] - starts[0], 1000);
        chk("basic_period2", starts[2] - starts[1], 1000);
        chk("basic_valid_lat", vrise[0] - starts[0], 72);
        chk("basic_frames", frame_cnt, 3);

        // Backpressure with stray done strobes
        ready_pct = 30; stray = 1'b1;
        step();
        enable = 1'b1;
        wait_frames(6, 3600);
        enable = 1'b0; ready_pct = 100; stray = 1'b0;
        chk("bp_overruns", overrun_cnt, 0);

        // Timeout: ADC 2 silent
        step();
        period = 32'd6000; adc_dly[2] = -1;
        step();
        enable = 1'b1;
        n = 0;
        while (!timeout && n < 12000) begin step(); n++; end
        if (!timeout) expire("wait_timeout");
        chk("tmo_latency", cyc - starts[$], 5000);
        chk("tmo_no_valid", s_if.m_valid_o, 0);
        adc_dly[2] = 70;
        step();
        chk("tmo_count", timeout_cnt, 1);
        wait_frames(7, 7000);
        enable = 1'b0;
        chk("tmo_after_frames", frame_cnt, 7);

        // Overrun: stalled stream while ticks keep coming
        step();
        period = 32'd20; ready_pct = 0;
        step();
        enable = 1'b1;
        repeat (300) step();
        enable = 1'b0; ready_pct = 100; s_if.m_ready_i = 1'b1;
        wait_frames(8, 100);
        chk("ovr_count", overrun_cnt, 14);
        chk("ovr_frames", frame_cnt, 8);

        // Clamp (period 0) and done coinciding with the timeout limit
        step();
        period = 32'd0; adc_dly[2] = TMO;
        step();
        enable = 1'b1;
        e_cyc = cyc;
        n = 0;
        while (!start_flag && n < 20) begin step(); n++; end
        chk("clamp_first_start", cyc - e_cyc, 2);
        n = 0;
        while (!s_if.m_valid_o && n < 6000) begin step(); n++; end
        if (!s_if.m_valid_o) expire("wait_valid_simul");
        enable = 1'b0;
        chk("simul_valid_lat", cyc - starts[$], 5002);
        wait_frames(9, 100);
        repeat (10) step();
        chk("simul_tmo_cnt", timeout_cnt, 1);
        chk("simul_idle", busy, 0);
        adc_dly[2] = 70;

        // Reset in the middle of a stream
        period = 32'd100;
        step();
        enable = 1'b1;
        n = 0;
        while (!(s_if.m_valid_o && s_if.m_ch_o == 5'd7) && n < 400) begin step(); n++; end
        if (!(s_if.m_valid_o && s_if.m_ch_o == 5'd7)) expire("wait_ch7");
        rst = 1'b1; enable = 1'b0;
        #1;
        chk("arst_valid", s_if.m_valid_o, 0);
        chk("arst_ch", s_if.m_ch_o, 0);
        chk("arst_data", s_if.m_data_o, 0);
        chk("arst_busy", busy, 0);
        chk("arst_frames", frame_cnt, 0);
        repeat (3) step();
        rst = 1'b0;
        step();
        enable = 1'b1;
        n = 0;
        while (!s_if.m_valid_o && n < 400) begin step(); n++; end
        if (!s_if.m_valid_o) expire("wait_valid_post_rst");
        chk("post_rst_ch", s_if.m_ch_o, 0);
        chk("post_rst_sof", s_if.m_sof_o, 1);
        wait_frames(1, 100);
        enable = 1'b0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
